adder_2: RTL and testbench

16-bit two-operand adder that forms the next/branch-target address in the datapath: the PC-side operand `aOO` is added to the instruction-memory-derived operand `insMem`. The block drives the sum combinationally on `o` for same-cycle use. It also keeps a registered copy with a valid flag and status flags for pipelined consumers.

---
 rtl/adder_2_pkg.sv | 15 +
 rtl/adder_2_core.sv | 34 +++
 rtl/adder_2.sv | 74 +++++++
 tb/tb_adder_2.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/adder_2_pkg.sv
// Shared types for the adder_2 address adder.
// The flag struct is used only when ADDER_2_FLAGS_EN is defined.
package adder_2_pkg;

  localparam int ADDR_W = 16;

  typedef logic [ADDR_W-1:0] addr_t;

  typedef struct packed {
    logic carry;
    logic ovf;
    logic zero;
  } adder_flags_t;

endpackage

// File: rtl/adder_2_core.sv
// Combinational adder that produces the sum and, optionally, the status flags.
// The flags port and its logic exist only when ADDER_2_FLAGS_EN is defined.
module adder_2_core
  import adder_2_pkg::*;
#(
  parameter int WIDTH = ADDR_W
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef ADDER_2_FLAGS_EN
  output adder_flags_t     flags,
`endif
  output logic [WIDTH-1:0] sum
);

`ifdef ADDER_2_FLAGS_EN
  logic [WIDTH:0] full_sum;

  // Widen by one bit so the unsigned carry-out is visible
  always_comb begin
    full_sum    = {1'b0, a} + {1'b0, b};
    sum         = full_sum[WIDTH-1:0];
    flags.carry = full_sum[WIDTH];
    flags.ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (full_sum[WIDTH-1] != a[WIDTH-1]);
    flags.zero  = (full_sum[WIDTH-1:0] == '0);
  end
`else
  // Without flags only the wrapped sum is needed
  always_comb begin
    sum = a + b;
  end
`endif

endmodule

// File: rtl/adder_2.sv
// Next/branch-target address adder: combinational sum on o plus a registered
// copy (o_q, out_valid) for pipelined consumers.
// Define ADDER_2_FLAGS_EN to add registered carry/overflow/zero flags.
module adder_2
  import adder_2_pkg::*;
#(
  parameter int WIDTH = ADDR_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] aOO,
  input  logic [WIDTH-1:0] insMem,
  input  logic             in_valid,
  output logic [WIDTH-1:0] o,
  output logic [WIDTH-1:0] o_q,
`ifdef ADDER_2_FLAGS_EN
  output logic             carry_q,
  output logic             ovf_q,
  output logic             zero_q,
`endif
  output logic             out_valid
);

  logic [WIDTH-1:0] sum;

`ifdef ADDER_2_FLAGS_EN
  adder_flags_t flags;
  adder_flags_t flags_q;

  adder_2_core #(.WIDTH(WIDTH)) u_core (
    .a     (aOO),
    .b     (insMem),
    .flags (flags),
    .sum   (sum)
  );
`else
  adder_2_core #(.WIDTH(WIDTH)) u_core (
    .a   (aOO),
    .b   (insMem),
    .sum (sum)
  );
`endif

  assign o = sum;

  // Capture the sum when operands are valid; valid flag tracks in_valid every cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_q       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        o_q <= sum;
      end
    end
  end

`ifdef ADDER_2_FLAGS_EN
  // Flags are captured alongside o_q and hold with it when in_valid is low
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q <= '0;
    end else if (in_valid) begin
      flags_q <= flags;
    end
  end

  assign carry_q = flags_q.carry;
  assign ovf_q   = flags_q.ovf;
  assign zero_q  = flags_q.zero;
`endif

endmodule

// File: tb/tb_adder_2.sv
// Self-checking bench for adder_2: table of vectors with hand-derived expected
// values, a scoreboard queue for the registered path, and a mid-cycle reset sequence.
// Flag checks are compiled in when ADDER_2_FLAGS_EN is defined.
module tb_adder_2;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        valid;
    logic [15:0] exp_sum;
    logic        exp_carry;
    logic        exp_ovf;
    logic        exp_zero;
  } vec_t;

  typedef struct {
    logic [15:0] sum;
    logic        carry;
    logic        ovf;
    logic        zero;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [15:0] aOO;
  logic [15:0] insMem;
  logic        in_valid;
  logic [15:0] o;
  logic [15:0] o_q;
  logic        out_valid;
`ifdef ADDER_2_FLAGS_EN
  logic        carry_q;
  logic        ovf_q;
  logic        zero_q;
`endif

  int   num_checks = 0;
  int   num_errors = 0;
  exp_t sb_queue[$];
  exp_t hold_exp;
  vec_t vecs[12];

  adder_2 #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .aOO       (aOO),
    .insMem    (insMem),
    .in_valid  (in_valid),
    .o         (o),
    .o_q       (o_q),
`ifdef ADDER_2_FLAGS_EN
    .carry_q   (carry_q),
    .ovf_q     (ovf_q),
    .zero_q    (zero_q),
`endif
    .out_valid (out_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    num_checks++;
    if (actual !== expected) begin
      num_errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkHeld(input string tag);
    checkOutput({tag, " o_q"}, {16'h0, o_q}, {16'h0, hold_exp.sum});
`ifdef ADDER_2_FLAGS_EN
    checkOutput({tag, " carry_q"}, {31'h0, carry_q}, {31'h0, hold_exp.carry});
    checkOutput({tag, " ovf_q"}, {31'h0, ovf_q}, {31'h0, hold_exp.ovf});
    checkOutput({tag, " zero_q"}, {31'h0, zero_q}, {31'h0, hold_exp.zero});
`endif
  endtask

  // Drive one vector on the falling edge, check o at once, then check the registered path after the next rising edge
  task automatic applyStimulus(input vec_t v, input int idx);
    exp_t e;
    string tag;
    tag = $sformatf("vec%0d", idx);
    @(negedge clk);
    aOO      = v.a;
    insMem   = v.b;
    in_valid = v.valid;
    #1;
    checkOutput({tag, " o"}, {16'h0, o}, {16'h0, v.exp_sum});
    if (v.valid) begin
      e.sum   = v.exp_sum;
      e.carry = v.exp_carry;
      e.ovf   = v.exp_ovf;
      e.zero  = v.exp_zero;
      sb_queue.push_back(e);
    end
    @(posedge clk);
    #1;
    checkOutput({tag, " out_valid"}, {31'h0, out_valid}, {31'h0, v.valid});
    if (out_valid === 1'b1) begin
      if (sb_queue.size() == 0) begin
        checkOutput({tag, " unexpected result"}, 32'h1, 32'h0);
      end else begin
        hold_exp = sb_queue.pop_front();
      end
    end
    checkHeld(tag);
  endtask

  initial begin
    vecs[0]  = '{16'h0003, 16'h0004, 1'b1, 16'h0007, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{16'h0004, 16'h0005, 1'b1, 16'h0009, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{16'h0006, 16'h0004, 1'b1, 16'h000A, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{16'hFFFF, 16'h0001, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[4]  = '{16'h7FFF, 16'h0001, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{16'h0F0F, 16'hF0F0, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{16'h8000, 16'hFFFF, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
    vecs[9]  = '{16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{16'hA5A5, 16'h5A5B, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[11] = '{16'h0004, 16'h0005, 1'b1, 16'h0009, 1'b0, 1'b0, 1'b0};

    hold_exp = '{16'h0000, 1'b0, 1'b0, 1'b0};
    rst      = 1'b1;
    aOO      = 16'h0000;
    insMem   = 16'h0000;
    in_valid = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset out_valid", {31'h0, out_valid}, 32'h0);
    checkHeld("reset");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i], i);
    end

    // Mid-cycle asynchronous reset with o_q holding 9; o must keep tracking live inputs
    aOO      = 16'h0100;
    insMem   = 16'h0023;
    in_valid = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    hold_exp = '{16'h0000, 1'b0, 1'b0, 1'b0};
    sb_queue.delete();
    checkOutput("async reset out_valid", {31'h0, out_valid}, 32'h0);
    checkHeld("async reset");
    checkOutput("async reset o live", {16'h0, o}, 32'h0123);
    @(posedge clk);
    #1;
    checkOutput("reset held out_valid", {31'h0, out_valid}, 32'h0);
    checkHeld("reset held");
    @(negedge clk);
    rst = 1'b0;

    // First valid result after reset
    applyStimulus('{16'h0100, 16'h0023, 1'b1, 16'h0123, 1'b0, 1'b0, 1'b0}, 100);
    applyStimulus('{16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0}, 101);

    checkOutput("scoreboard drained", sb_queue.size(), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule
